// File: rtl/adam_stream_ser.sv
// adam_stream_ser: wide-to-narrow stream serializer, RATIO beats per word.
// Define ADAM_STREAM_SER_LAST_EN to add the mst_last end-of-word flag.
module adam_stream_ser #(
  parameter int DATA_WIDTH = 32,
  parameter int RATIO      = 4,
  parameter int MSB_FIRST  = 0,
  localparam int BEAT_W    = DATA_WIDTH / RATIO,
  localparam int CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] slv_data,
  input  logic                  slv_valid,
  output logic                  slv_ready,
`ifdef ADAM_STREAM_SER_LAST_EN
  output logic                  mst_last,
`endif
  output logic [BEAT_W-1:0]     mst_data,
  output logic                  mst_valid,
  input  logic                  mst_ready
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      sel;
  logic [DATA_WIDTH-1:0] word_q;
  logic                  busy;
  logic                  last;
  logic                  accept;

  assign busy      = (state == SEND);
  assign last      = (cnt == CNT_MAX);
  // Final-beat handshake frees the buffer in the same cycle: zero bubble.
  assign slv_ready = rst_n && (!busy || (mst_ready && last));
  assign accept    = slv_valid && slv_ready;
  assign mst_valid = busy;

  always_comb begin
    sel = cnt;
    if (MSB_FIRST != 0) sel = CNT_MAX - cnt;
  end

  assign mst_data = BEAT_W'(word_q >> (int'(sel) * BEAT_W));

`ifdef ADAM_STREAM_SER_LAST_EN
  assign mst_last = busy && last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      word_q <= '0;
    end else if (accept) begin
      state  <= SEND;
      cnt    <= '0;
      word_q <= slv_data;
    end else if (busy && mst_ready) begin
      if (last) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
